axis_width_down: RTL and testbench



---
 rtl/rz_axis_pkg.sv | 16 +
 rtl/axis_width_down_if.sv | 15 +
 rtl/axis_shift_hold.sv | 49 ++++
 rtl/axis_width_down.sv | 84 ++++++++
 tb/tb_axis_width_down.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rz_axis_pkg.sv
// Shared helpers for AXI-Stream width converters.
// Latency: n/a (elaboration-time functions only).
// Backpressure: n/a.
package rz_axis_pkg;

  // Number of narrow beats carried by one wide word.
  function automatic int ratio_f(input int dw, input int ow);
    return dw / ow;
  endfunction

  // Bits needed for a counter spanning 0..n-1, never less than one bit.
  function automatic int width_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_width_down_if.sv
// AXI-Stream bundle with frame sideband; one instance per stream.
// Latency: n/a (wiring only).
// Backpressure: tready flows from slave back to master.
interface axis_width_down_if #(
  parameter int W = 8
);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tuser;
  logic         tlast;

  modport master (output tvalid, tdata, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/axis_shift_hold.sv
// Holding shift register that serialises a wide word into OW-bit slices, LSB first.
// Latency: loaded word presents slice 0 on the next cycle.
// Backpressure: state only advances on load or consume; otherwise frozen.
module axis_shift_hold
  import rz_axis_pkg::*;
#(
  parameter int DW = 24,
  parameter int OW = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                load,
  input  logic [DW-1:0]                       load_data,
  input  logic                                consume,
  output logic                                full,
  output logic [width_f(ratio_f(DW, OW))-1:0] beat,
  output logic                                last_beat,
  output logic [OW-1:0]                       data
);
  localparam int RATIO = ratio_f(DW, OW);
  localparam int BW = width_f(RATIO);
  localparam logic [BW-1:0] BEAT_LAST = BW'(RATIO - 1);

  logic [DW-1:0] sreg;

  // A load always wins: it only happens when the register is empty or its final slice is leaving.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      beat <= '0;
      sreg <= '0;
    end else if (load) begin
      full <= 1'b1;
      beat <= '0;
      sreg <= load_data;
    end else if (consume) begin
      if (last_beat) begin
        full <= 1'b0;
        beat <= '0;
      end else begin
        sreg <= sreg >> OW;
        beat <= beat + 1'b1;
      end
    end
  end

  assign last_beat = (beat == BEAT_LAST);
  assign data      = sreg[OW-1:0];
endmodule

// File: rtl/axis_width_down.sv
// Splits DW-bit stream words into DW/OW beats LSB first, adding tuser/tlast frame markers.
// Latency: accepted word shows its first beat one cycle later; zero-bubble under continuous flow.
// Backpressure: m_axis.tready low freezes everything; s_axis.tready low while a word is held.
module axis_width_down
  import rz_axis_pkg::*;
#(
  parameter int DW          = 24,
  parameter int OW          = 8,
  parameter int FRAME_WORDS = 640
) (
  input  logic               clk,
  input  logic               reset,
  axis_width_down_if.slave   s_axis,
  axis_width_down_if.master  m_axis,
  output logic               frame_done
);
  localparam int RATIO = ratio_f(DW, OW);
  localparam int BW = width_f(RATIO);
  localparam int WW = width_f(FRAME_WORDS);
  localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);

  if (DW % OW != 0) begin : g_bad_multiple
    $fatal(1, "axis_width_down: DW must be a multiple of OW");
  end
  if (DW / OW < 2) begin : g_bad_ratio
    $fatal(1, "axis_width_down: DW/OW must be at least 2");
  end
  if (FRAME_WORDS < 1) begin : g_bad_frame
    $fatal(1, "axis_width_down: FRAME_WORDS must be at least 1");
  end

  logic          full;
  logic          last_beat;
  logic [BW-1:0] beat;
  logic          m_accept;
  logic          s_accept;
  logic [WW-1:0] word;
  logic          first_word;
  logic          last_word;
  logic          unused_sideband;

  // Input sideband has no meaning for a down-converter; frames are counted here instead.
  assign unused_sideband = s_axis.tuser ^ s_axis.tlast;

  assign m_accept      = full & m_axis.tready;
  assign s_axis.tready = ~full | (m_accept & last_beat);
  assign s_accept      = s_axis.tvalid & s_axis.tready;

  axis_shift_hold #(
    .DW(DW),
    .OW(OW)
  ) u_hold (
    .clk      (clk),
    .reset    (reset),
    .load     (s_accept),
    .load_data(s_axis.tdata),
    .consume  (m_accept),
    .full     (full),
    .beat     (beat),
    .last_beat(last_beat),
    .data     (m_axis.tdata)
  );

  assign m_axis.tvalid = full;
  assign m_axis.tuser  = full & first_word & (beat == '0);
  assign m_axis.tlast  = full & last_word & last_beat;

  // Word position within the frame is latched per word so markers stay stable while it drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      word       <= '0;
      first_word <= 1'b0;
      last_word  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= m_accept & m_axis.tlast;
      if (s_accept) begin
        first_word <= (word == '0);
        last_word  <= (word == WORD_LAST);
        word       <= (word == WORD_LAST) ? '0 : word + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axis_width_down.sv
// Randomised scoreboard bench for axis_width_down (24->8, 640-word frames) plus a 32->8 single-word-frame instance.
// Inputs change on the falling edge; everything is sampled 2 time units later.
// A reference model turns each accepted word into its expected byte beats and frame markers.
module tb_axis_width_down;
  logic clk = 1'b0;
  logic reset;
  logic fd0, fd1;
  logic rand_rdy;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axis_width_down_if #(.W(24)) s0 ();
  axis_width_down_if #(.W(8))  m0 ();
  axis_width_down_if #(.W(32)) s1 ();
  axis_width_down_if #(.W(8))  m1 ();

  axis_width_down #(.DW(24), .OW(8), .FRAME_WORDS(640)) dut0 (
    .clk(clk), .reset(reset), .s_axis(s0), .m_axis(m0), .frame_done(fd0)
  );
  axis_width_down #(.DW(32), .OW(8), .FRAME_WORDS(1)) dut1 (
    .clk(clk), .reset(reset), .s_axis(s1), .m_axis(m1), .frame_done(fd1)
  );

  typedef struct {
    logic [7:0] dat;
    logic       user;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  beat_t b_push, e_mon;
  int    word_idx = 0;
  int    cyc = 0, beats = 0, first_cyc = 0, last_cyc = 0;
  int    n_user = 0, n_last = 0, n_fd = 0;
  logic  fd_pend = 1'b0, prev_stall = 1'b0;
  logic [7:0] prev_dat = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Downstream ready: random when enabled, otherwise always ready.
  always @(negedge clk) m0.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;

  // Reference model: each accepted word becomes three byte beats, byte 0 first.
  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      exp_q.delete();
      word_idx = 0;
    end else if (s0.tvalid && s0.tready) begin
      for (int k = 0; k < 3; k++) begin
        b_push.dat  = s0.tdata[8*k +: 8];
        b_push.user = (word_idx % 640 == 0) && (k == 0);
        b_push.last = (word_idx % 640 == 639) && (k == 2);
        exp_q.push_back(b_push);
      end
      word_idx++;
    end
  end

  // Monitor: compare accepted beats, AXIS stability and frame_done timing.
  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (reset) begin
      fd_pend    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("frame_done", fd0, fd_pend);
      if (fd0) n_fd++;
      if (prev_stall) begin
        check("hold_valid", m0.tvalid, 1);
        check("hold_data", m0.tdata, prev_dat);
      end
      if (m0.tvalid && m0.tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_beat: got %0h expected no beat", m0.tdata);
        end else begin
          e_mon = exp_q.pop_front();
          check("beat_data", m0.tdata, e_mon.dat);
          check("beat_user", m0.tuser, e_mon.user);
          check("beat_last", m0.tlast, e_mon.last);
        end
        if (beats == 0) first_cyc = cyc;
        last_cyc = cyc;
        beats++;
        if (m0.tuser) n_user++;
        if (m0.tlast) n_last++;
      end
      fd_pend    = m0.tvalid && m0.tready && m0.tlast;
      prev_stall = m0.tvalid && !m0.tready;
      prev_dat   = m0.tdata;
    end
  end

  // Call just after a falling edge; returns on the falling edge after the word is taken.
  task automatic send(input logic [23:0] d);
    int n = 0;
    s0.tvalid = 1'b1;
    s0.tdata  = d;
    #2;
    while (!s0.tready && n < 1000) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no tready expected tready within 1000 cycles");
    end
    @(negedge clk);
    s0.tvalid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || m0.tvalid) && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("drain", (exp_q.size() == 0) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clear_counts();
    beats  = 0;
    n_user = 0;
    n_last = 0;
    n_fd   = 0;
  endtask

  initial begin
    logic [31:0] w1;
    int          fd1_cnt;
    reset = 1'b1;
    rand_rdy = 1'b0;
    s0.tuser = 1'b0; s0.tlast = 1'b0; s0.tdata = '0;
    s1.tuser = 1'b0; s1.tlast = 1'b0; s1.tdata = '0;
    m1.tready = 1'b1;

    // Reset held with valid asserted upstream.
    s0.tvalid = 1'b1;
    s1.tvalid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tvalid", m0.tvalid, 0);
    check("rst_tuser", m0.tuser, 0);
    check("rst_tlast", m0.tlast, 0);
    check("rst_frame_done", fd0, 0);
    check("rst_tdata", m0.tdata, 0);
    check("rst_tvalid_32", m1.tvalid, 0);
    @(negedge clk);
    reset = 1'b0;
    s0.tvalid = 1'b0;
    s1.tvalid = 1'b0;
    #1;
    check("tready_after_rst", s0.tready, 1);
    check("tready_after_rst_32", s1.tready, 1);

    // Single word, exact beat timing.
    @(negedge clk);
    send(24'hA1B2C3);
    #2;
    check("w0_b0_valid", m0.tvalid, 1);
    check("w0_b0_data", m0.tdata, 8'hC3);
    check("w0_b0_user", m0.tuser, 1);
    @(negedge clk);
    #2;
    check("w0_b1_data", m0.tdata, 8'hB2);
    @(negedge clk);
    #2;
    check("w0_b2_data", m0.tdata, 8'hA1);
    check("w0_b2_last", m0.tlast, 0);
    @(negedge clk);
    #2;
    check("w0_empty", m0.tvalid, 0);

    // One full frame at full throughput, then the first word of the next frame.
    do_reset();
    clear_counts();
    for (int i = 0; i < 640; i++) send(24'($urandom));
    wait_drain(50);
    check("frame_beats", beats, 1920);
    check("frame_no_bubble", last_cyc - first_cyc, 1919);
    check("frame_tuser_cnt", n_user, 1);
    check("frame_tlast_cnt", n_last, 1);
    check("frame_done_cnt", n_fd, 1);
    send(24'($urandom));
    wait_drain(50);
    check("word641_tuser", n_user, 2);

    // Random valid/ready over three frames.
    do_reset();
    clear_counts();
    rand_rdy = 1'b1;
    for (int i = 0; i < 1920; i++) begin
      while ($urandom_range(0, 9) < 3) @(negedge clk);
      send(24'($urandom));
    end
    wait_drain(500);
    rand_rdy = 1'b0;
    check("rand_tuser_cnt", n_user, 3);
    check("rand_tlast_cnt", n_last, 3);
    check("rand_fd_cnt", n_fd, 3);
    check("rand_beats", beats, 5760);

    // Reset while word 5 is mid-way through its beats.
    do_reset();
    for (int i = 0; i < 6; i++) send(24'($urandom));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_dropped", m0.tvalid, 0);
    clear_counts();
    for (int i = 0; i < 640; i++) send(24'($urandom));
    wait_drain(50);
    check("midrst_tuser_cnt", n_user, 1);
    check("midrst_tlast_cnt", n_last, 1);
    check("midrst_fd_cnt", n_fd, 1);

    // Single-word frames on the 32-bit instance.
    w1 = 32'h44332211;
    fd1_cnt = 0;
    @(negedge clk);
    s1.tvalid = 1'b1;
    s1.tdata  = w1;
    #2;
    check("w32_tready", s1.tready, 1);
    @(negedge clk);
    s1.tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #2;
      check("w32_valid", m1.tvalid, 1);
      check("w32_data", m1.tdata, w1[8*k +: 8]);
      check("w32_user", m1.tuser, (k == 0) ? 1 : 0);
      check("w32_last", m1.tlast, (k == 3) ? 1 : 0);
      if (fd1) fd1_cnt++;
      @(negedge clk);
    end
    #2;
    check("w32_empty", m1.tvalid, 0);
    if (fd1) fd1_cnt++;
    @(negedge clk);
    #2;
    if (fd1) fd1_cnt++;
    check("w32_fd_cnt", fd1_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
